// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU datapath: ALU opcodes,
// operand-B select codes, memory-read FSM encoding and flag reset values.
package cpu_pkg;

  // ALU opcodes; any code above OP_DEC passes A through unchanged
  localparam int OP_PASS_B = 0;
  localparam int OP_ADD    = 1;
  localparam int OP_SUB    = 2;
  localparam int OP_AND    = 3;
  localparam int OP_OR     = 4;
  localparam int OP_XOR    = 5;
  localparam int OP_NOT_A  = 6;
  localparam int OP_SHL    = 7;
  localparam int OP_SHR    = 8;
  localparam int OP_INC    = 9;
  localparam int OP_DEC    = 10;

  // Operand-B source selects
  localparam int SEL_IMM  = 0;
  localparam int SEL_REG  = 1;
  localparam int SEL_MEM  = 2;
  localparam int SEL_PORT = 3;

  // Memory-read sequencing FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  // Flag values after reset (acc resets to zero, so Z starts set)
  localparam logic RST_Z = 1'b1;
  localparam logic RST_C = 1'b0;
  localparam logic RST_N = 1'b0;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result truncated to WIDTH, c carries the
// carry/borrow/shifted-out bit depending on the opcode.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [IWIDTH-1:0] op,
  output logic [WIDTH-1:0]  result,
  output logic              c
);

  logic [WIDTH:0] ext;

  // Opcode decode; ext is one bit wider so bit WIDTH holds carry or borrow
  always_comb begin
    result = '0;
    c      = 1'b0;
    ext    = '0;
    case (int'(op))
      OP_PASS_B: result = b;
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT_A: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c      = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        c      = a[0];
      end
      OP_INC: begin
        ext    = {1'b0, a} + (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - (WIDTH+1)'(1);
        result = ext[WIDTH-1:0];
        c      = ext[WIDTH];
      end
      default: result = a;
    endcase
  end

endmodule

// File: rtl/cpu_data_mc.sv
// Multi-cycle CPU datapath: accumulator, register file, data memory,
// ALU and Z/C/N flags. A memory operand costs one extra cycle with stall
// high; all other operands complete in one cycle.
//
// Handshake: stall is high exactly while the FSM is in MEM_RD. During that
// cycle every input is ignored and the controller must hold its outputs
// stable (PC held); the accumulator is written on the edge that leaves
// MEM_RD, so a new request may be presented in the following (EXEC) cycle.
module cpu_data_mc
  import cpu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int IWIDTH         = 4,
  parameter int REG_SIZE       = 9,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int D_MEM_DEPTH    = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_F_SEL_SIZE-1:0] reg_f_sel,
  input  logic                      en_reg_f,
  output logic [WIDTH-1:0]          port,
  input  logic [WIDTH-1:0]          port_in,
  input  logic [WIDTH-1:0]          d_mem_addr,
  input  logic                      d_mem_addr_mode,
  input  logic                      en_d_mem,
  input  logic [IN_B_SEL_SIZE-1:0]  in_b_sel,
  input  logic [WIDTH-1:0]          imm,
  input  logic [IWIDTH-1:0]         alu_op,
  input  logic                      en_acc,
  output logic [WIDTH-1:0]          acc_out,
  output logic                      flag_z_out,
  output logic                      flag_c_out,
  output logic                      flag_n_out,
  output logic                      stall,
  output logic [1:0]                fsm_state
);

  localparam int AW = (D_MEM_DEPTH > 1) ? $clog2(D_MEM_DEPTH) : 1;

  logic [WIDTH-1:0]  regs [REG_SIZE];
  logic [WIDTH-1:0]  mem  [D_MEM_DEPTH];

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  acc;
  logic              flag_z, flag_c, flag_n;
  logic [WIDTH-1:0]  rd_q;
  logic [IWIDTH-1:0] op_q;

  logic [WIDTH-1:0]  rf_rd;
  logic [WIDTH-1:0]  eff_addr;
  logic [AW-1:0]     mem_idx;
  logic [WIDTH-1:0]  b_mux;
  logic [WIDTH-1:0]  alu_b;
  logic [IWIDTH-1:0] alu_op_m;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_c;
  logic              accept;
  logic              mem_req;
  logic              acc_wr;

  // Register file read; indices past the last register read as zero
  always_comb begin
    rf_rd = '0;
    for (int i = 0; i < REG_SIZE; i++) begin
      if (int'(reg_f_sel) == i) rf_rd = regs[i];
    end
  end

  assign eff_addr = d_mem_addr_mode ? rf_rd : d_mem_addr;
  assign mem_idx  = AW'(int'(eff_addr) % D_MEM_DEPTH);

  assign accept  = (state != ST_MEM_RD);
  assign mem_req = accept && en_acc && (int'(in_b_sel) == SEL_MEM);
  assign acc_wr  = (state == ST_MEM_RD) ||
                   (accept && en_acc && (int'(in_b_sel) != SEL_MEM));

  // Operand-B select for single-cycle operations
  always_comb begin
    b_mux = '0;
    case (int'(in_b_sel))
      SEL_IMM:  b_mux = imm;
      SEL_REG:  b_mux = rf_rd;
      SEL_PORT: b_mux = port_in;
      default:  b_mux = '0;
    endcase
  end

  // In MEM_RD the ALU works on the latched opcode and registered read data
  assign alu_b    = (state == ST_MEM_RD) ? rd_q : b_mux;
  assign alu_op_m = (state == ST_MEM_RD) ? op_q : alu_op;

  cpu_alu #(
    .WIDTH  (WIDTH),
    .IWIDTH (IWIDTH)
  ) u_alu (
    .a      (acc),
    .b      (alu_b),
    .op     (alu_op_m),
    .result (alu_res),
    .c      (alu_c)
  );

  // FSM state register; reset drops out of MEM_RD immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: a memory operand detours through MEM_RD for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = mem_req ? ST_MEM_RD : ST_IDLE;
      ST_MEM_RD: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = mem_req ? ST_MEM_RD : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Accumulator, flags and latched opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      flag_z <= RST_Z;
      flag_c <= RST_C;
      flag_n <= RST_N;
      op_q   <= '0;
    end else begin
      if (mem_req) op_q <= alu_op;
      if (acc_wr) begin
        acc    <= alu_res;
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
        flag_n <= alu_res[WIDTH-1];
      end
    end
  end

  // Register file write of the pre-update accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_SIZE; i++) begin
        if (accept && en_reg_f && (int'(reg_f_sel) == i)) regs[i] <= acc;
      end
    end
  end

  // Data memory: write and registered read share an address, read-first
  always_ff @(posedge clk) begin
    if (accept && en_d_mem) mem[mem_idx] <= acc;
    if (mem_req)            rd_q         <= mem[mem_idx];
  end

  assign port       = regs[REG_SIZE-1];
  assign acc_out    = acc;
  assign flag_z_out = flag_z;
  assign flag_c_out = flag_c;
  assign flag_n_out = flag_n;
  assign stall      = (state == ST_MEM_RD);
  assign fsm_state  = state;

endmodule

// File: tb/tb_cpu_data_mc.sv
// Bench for cpu_data_mc: directed walk through the main behaviours, then
// randomized operations checked against an arithmetic reference model.
module tb_cpu_data_mc;

  localparam int W     = 8;
  localparam int IW    = 4;
  localparam int RS    = 9;
  localparam int RFS   = 4;
  localparam int BS    = 2;
  localparam int DEPTH = 256;
  localparam int MASK  = (1 << W) - 1;
  localparam int HALF  = 1 << (W - 1);

  logic           clk;
  logic           rst_n;
  logic [RFS-1:0] reg_f_sel;
  logic           en_reg_f;
  logic [W-1:0]   port;
  logic [W-1:0]   port_in;
  logic [W-1:0]   d_mem_addr;
  logic           d_mem_addr_mode;
  logic           en_d_mem;
  logic [BS-1:0]  in_b_sel;
  logic [W-1:0]   imm;
  logic [IW-1:0]  alu_op;
  logic           en_acc;
  logic [W-1:0]   acc_out;
  logic           flag_z_out, flag_c_out, flag_n_out;
  logic           stall;
  logic [1:0]     fsm_state;

  cpu_data_mc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg_f_sel       (reg_f_sel),
    .en_reg_f        (en_reg_f),
    .port            (port),
    .port_in         (port_in),
    .d_mem_addr      (d_mem_addr),
    .d_mem_addr_mode (d_mem_addr_mode),
    .en_d_mem        (en_d_mem),
    .in_b_sel        (in_b_sel),
    .imm             (imm),
    .alu_op          (alu_op),
    .en_acc          (en_acc),
    .acc_out         (acc_out),
    .flag_z_out      (flag_z_out),
    .flag_c_out      (flag_c_out),
    .flag_n_out      (flag_n_out),
    .stall           (stall),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  int m_regs [RS];
  int m_mem  [DEPTH];
  int m_acc, m_z, m_c, m_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int m_reg_rd(input int i);
    return (i < RS) ? m_regs[i] : 0;
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int cy);
    cy = 0;
    case (op)
      0:  r = b;
      1:  begin r = a + b; cy = int'(r > MASK); end
      2:  begin r = a - b; cy = int'(a < b); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = MASK - a;
      7:  begin r = a * 2; cy = int'(a >= HALF); end
      8:  begin r = a / 2; cy = a % 2; end
      9:  begin r = a + 1; cy = int'(a == MASK); end
      10: begin r = a - 1; cy = int'(a == 0); end
      default: r = a;
    endcase
    r = r & MASK;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_z = 1; m_c = 0; m_n = 0;
    for (int i = 0; i < RS; i++) m_regs[i] = 0;
  endtask

  task automatic clear_enables();
    en_acc = 1'b0; en_reg_f = 1'b0; en_d_mem = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_op(input bit ea, input int sel, input int aop, input int imm_v,
                       input int pin, input int rs, input bit erf, input bit edm,
                       input int addr, input bit mode);
    int b, r, cy, ad;
    bit is_mem;
    en_acc = ea; in_b_sel = BS'(sel); alu_op = IW'(aop); imm = W'(imm_v);
    port_in = W'(pin); reg_f_sel = RFS'(rs); en_reg_f = erf; en_d_mem = edm;
    d_mem_addr = W'(addr); d_mem_addr_mode = mode;

    ad     = (mode ? m_reg_rd(rs) : addr) % DEPTH;
    is_mem = ea && (sel == 2);
    case (sel)
      0:       b = imm_v;
      1:       b = m_reg_rd(rs);
      2:       b = m_mem[ad];
      default: b = pin;
    endcase
    if (erf && rs < RS) m_regs[rs] = m_acc;
    if (edm) m_mem[ad] = m_acc;
    if (ea) begin
      ref_alu(aop, m_acc, b, r, cy);
      m_acc = r; m_c = cy; m_z = int'(r == 0); m_n = int'(r >= HALF);
    end
    exp_q.push_back(W'(m_acc));

    @(posedge clk); @(negedge clk);
    clear_enables();
    if (is_mem) begin
      check("stall_hi", 32'(stall), 1);
      // junk requests while stalled must be ignored
      en_acc = 1'($urandom_range(0, 1)); en_reg_f = 1'($urandom_range(0, 1));
      en_d_mem = 1'($urandom_range(0, 1)); reg_f_sel = RFS'($urandom_range(0, 15));
      in_b_sel = BS'($urandom_range(0, 3)); alu_op = IW'($urandom_range(0, 15));
      imm = W'($urandom_range(0, MASK)); d_mem_addr = W'($urandom_range(0, MASK));
      @(posedge clk); @(negedge clk);
      clear_enables();
    end
    check("stall_lo", 32'(stall), 0);
    check("acc", 32'(acc_out), 32'(exp_q.pop_front()));
    check("flag_z", 32'(flag_z_out), m_z);
    check("flag_c", 32'(flag_c_out), m_c);
    check("flag_n", 32'(flag_n_out), m_n);
    check("port", 32'(port), m_regs[RS-1]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    reg_f_sel = '0; port_in = '0; d_mem_addr = '0; d_mem_addr_mode = 1'b0;
    in_b_sel = '0; imm = '0; alu_op = '0;
    clear_enables();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_acc",   32'(acc_out),    0);
    check("rst_z",     32'(flag_z_out), 1);
    check("rst_c",     32'(flag_c_out), 0);
    check("rst_n",     32'(flag_n_out), 0);
    check("rst_stall", 32'(stall),      0);
    check("rst_port",  32'(port),       0);

    // LDI, direct store, register round trip
    do_op(1, 0, 0, 'h69, 0, 0, 0, 0, 0, 0);
    check("ldi_69", 32'(acc_out), 'h69);
    check("ldi_z",  32'(flag_z_out), 0);
    do_op(0, 0, 0, 0, 0, 0, 0, 1, 'h00, 0);
    do_op(1, 0, 0, 'h11, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    do_op(1, 0, 0, 'h22, 0, 0, 0, 0, 0, 0);
    do_op(1, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    check("ld_r3", 32'(acc_out), 'h11);

    // memory ADD with stall
    do_op(1, 2, 1, 0, 0, 0, 0, 0, 'h00, 0);
    check("mem_add", 32'(acc_out), 'h7A);
    check("mem_add_c", 32'(flag_c_out), 0);

    // borrow and shift flags
    do_op(1, 0, 0, 'h05, 0, 0, 0, 0, 0, 0);
    do_op(1, 0, 2, 'h06, 0, 0, 0, 0, 0, 0);
    check("sub_acc", 32'(acc_out), 'hFF);
    check("sub_c",   32'(flag_c_out), 1);
    check("sub_n",   32'(flag_n_out), 1);
    do_op(1, 0, 0, 'h80, 0, 0, 0, 0, 0, 0);
    do_op(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    check("shl_acc", 32'(acc_out), 'h00);
    check("shl_c",   32'(flag_c_out), 1);
    check("shl_z",   32'(flag_z_out), 1);

    // indirect store through R2, direct reload
    do_op(1, 0, 0, 'h10, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    do_op(1, 0, 0, 'h3C, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 2, 0, 1, 0, 1);
    do_op(1, 0, 0, 'h00, 0, 0, 0, 0, 0, 0);
    do_op(1, 2, 0, 0, 0, 0, 0, 0, 'h10, 0);
    check("ind_ld", 32'(acc_out), 'h3C);

    // port register, external operand, out-of-range register
    do_op(1, 0, 0, 'hA5, 0, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 0, 8, 1, 0, 0, 0);
    check("port_a5", 32'(port), 'hA5);
    do_op(1, 3, 0, 0, 'h07, 0, 0, 0, 0, 0);
    check("port_in", 32'(acc_out), 'h07);
    do_op(0, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    do_op(1, 1, 0, 0, 0, 12, 0, 0, 0, 0);
    check("oor_rd", 32'(acc_out), 0);

    // reset asserted mid-MEM_RD
    do_op(1, 0, 0, 'h5A, 0, 0, 0, 0, 0, 0);
    en_acc = 1'b1; in_b_sel = BS'(2); alu_op = IW'(1); d_mem_addr = '0; d_mem_addr_mode = 1'b0;
    @(posedge clk); @(negedge clk);
    clear_enables();
    check("mid_stall_hi", 32'(stall), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_acc",   32'(acc_out), 0);
    check("mid_rst_z",     32'(flag_z_out), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 32'(fsm_state), 0);

    // fill memory so random reads are defined
    for (int i = 0; i < DEPTH; i++)
      do_op(1, 0, 0, $urandom_range(0, MASK), 0, 0, 0, 1, i, 0);

    // randomized operations
    for (int k = 0; k < 400; k++) begin
      do_op(bit'($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 15),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) == 0),
            $urandom_range(0, MASK), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
